// File: rtl/div_arbiter_if.sv
// ---------------------------------------------------------------------------
// div_arbiter_if
// Bundles the voice request side and the shared-divider side of div_arbiter.
//
// Signals:
//   en           global enable (low freezes the arbiter)
//   req          per-voice request level, N bits
//   operand      flattened operands, voice i at [i*DW +: DW]
//   div_done     divider completion strobe
//   div_result   divider quotient, valid with div_done
//   div_start    one-cycle start pulse to the divider
//   div_operand  operand of the granted voice
//   ack          one-hot acknowledge to the granted voice
//   result_valid one-cycle strobe qualifying result/result_id
//   result       registered quotient
//   result_id    index of the voice owning result
//   busy         arbiter not idle
//   timeout_err  sticky abort flag
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (voices, divider, bench)
// ---------------------------------------------------------------------------
interface div_arbiter_if #(
    parameter int N  = 13,
    parameter int DW = 16,
    parameter int IW = 7
);
    logic            en;
    logic [N-1:0]    req;
    logic [N*DW-1:0] operand;
    logic            div_done;
    logic [DW-1:0]   div_result;
    logic            div_start;
    logic [DW-1:0]   div_operand;
    logic [N-1:0]    ack;
    logic            result_valid;
    logic [DW-1:0]   result;
    logic [IW-1:0]   result_id;
    logic            busy;
    logic            timeout_err;

    modport slave (
        input  en, req, operand, div_done, div_result,
        output div_start, div_operand, ack, result_valid, result, result_id,
               busy, timeout_err
    );

    modport master (
        output en, req, operand, div_done, div_result,
        input  div_start, div_operand, ack, result_valid, result, result_id,
               busy, timeout_err
    );
endinterface

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Round-robin scheduler sharing one sequential divider among N voices of the
// polyphonic oscillator. A pending voice is granted, its operand is sent to
// the divider with a start pulse, and when the divider reports done the
// quotient is returned tagged with the voice index while that voice is acked.
//
// Ports:
//   MHz10  system clock, rising edge
//   rst    synchronous active-high reset
//   bus    div_arbiter_if.slave (request, divider and result signals)
//
// Parameters: N voices, DW data width, IW index width (2**IW >= N),
//             TIMEOUT wait limit in cycles.
//
// Optional feature macro: DIV_TIMEOUT_EN
//   defined     - WAIT aborts after TIMEOUT cycles without div_done, the
//                 result is forced to 0 and the sticky timeout_err is set.
//   not defined - WAIT lasts until div_done; timeout_err is tied low.
// ---------------------------------------------------------------------------
module div_arbiter #(
    parameter int N       = 13,
    parameter int DW      = 16,
    parameter int IW      = 7,
    parameter int TIMEOUT = 64
) (
    input logic          MHz10,
    input logic          rst,
    div_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grantId_q, grantId_d;
    logic [DW-1:0] result_q, result_d;
    logic [IW-1:0] resultId_q, resultId_d;
    logic [DW-1:0] heldOperand_q, heldOperand_d;

    logic [IW-1:0] pickId;
    logic [IW-1:0] pickLo;
    logic [IW-1:0] pickHi;
    logic          foundHi;
    logic [DW-1:0] grantOperand;
    logic [N-1:0]  ackOneHot;

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] waitCnt_q, waitCnt_d;
    logic          timeoutErr_q, timeoutErr_d;
`endif

    // Round-robin pick: scanning downwards leaves the lowest requesting index
    // overall in pickLo and the lowest one at or above ptr in pickHi. The
    // upper search wins so a voice just served goes to the back of the line.
    always_comb begin
        pickLo  = '0;
        pickHi  = '0;
        foundHi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                pickLo = IW'(i);
                if (IW'(i) >= ptr_q) begin
                    pickHi  = IW'(i);
                    foundHi = 1'b1;
                end
            end
        end
        pickId = foundHi ? pickHi : pickLo;
    end

    assign grantOperand = bus.operand[grantId_q*DW +: DW];
    assign ackOneHot    = {{(N-1){1'b0}}, 1'b1} << grantId_q;

    // State and datapath registers; en low holds everything through the
    // next-state defaults below.
    always_ff @(posedge MHz10) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grantId_q     <= '0;
            result_q      <= '0;
            resultId_q    <= '0;
            heldOperand_q <= '0;
`ifdef DIV_TIMEOUT_EN
            waitCnt_q     <= '0;
            timeoutErr_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grantId_q     <= grantId_d;
            result_q      <= result_d;
            resultId_q    <= resultId_d;
            heldOperand_q <= heldOperand_d;
`ifdef DIV_TIMEOUT_EN
            waitCnt_q     <= waitCnt_d;
            timeoutErr_q  <= timeoutErr_d;
`endif
        end
    end

    // Next-state logic. The operand is captured during ISSUE so that later
    // changes on the voice side cannot disturb a division in flight.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grantId_d     = grantId_q;
        result_d      = result_q;
        resultId_d    = resultId_q;
        heldOperand_d = heldOperand_q;
`ifdef DIV_TIMEOUT_EN
        waitCnt_d     = waitCnt_q;
        timeoutErr_d  = timeoutErr_q;
`endif
        if (bus.en) begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        grantId_d = pickId;
                        state_d   = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    heldOperand_d = grantOperand;
                    state_d       = ST_WAIT;
`ifdef DIV_TIMEOUT_EN
                    waitCnt_d     = '0;
`endif
                end
                ST_WAIT: begin
                    if (bus.div_done) begin
                        result_d   = bus.div_result;
                        resultId_d = grantId_q;
                        state_d    = ST_DONE;
                    end
`ifdef DIV_TIMEOUT_EN
                    // The count would reach TIMEOUT on this edge, so the
                    // abort is taken here and DONE lands TIMEOUT cycles after
                    // WAIT was entered.
                    else if (waitCnt_q == CW'(TIMEOUT - 1)) begin
                        result_d     = '0;
                        resultId_d   = grantId_q;
                        timeoutErr_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    ptr_d   = (grantId_q == IW'(N - 1)) ? '0 : grantId_q + 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Moore strobes from the registered state, suppressed while disabled.
    assign bus.div_start    = bus.en && (state_q == ST_ISSUE);
    assign bus.result_valid = bus.en && (state_q == ST_DONE);
    assign bus.ack          = (bus.en && (state_q == ST_DONE)) ? ackOneHot : '0;
    assign bus.div_operand  = (state_q == ST_ISSUE) ? grantOperand : heldOperand_q;
    assign bus.result       = result_q;
    assign bus.result_id    = resultId_q;
    assign bus.busy         = (state_q != ST_IDLE);

`ifdef DIV_TIMEOUT_EN
    assign bus.timeout_err  = timeoutErr_q;
`else
    assign bus.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter
// Directed bench for div_arbiter: reset state, single transaction latency,
// round-robin fairness, enable freeze, reset abort and the wait timeout
// (timeout path only when DIV_TIMEOUT_EN is defined).
// ---------------------------------------------------------------------------
module tb_div_arbiter;

    localparam int N       = 13;
    localparam int DW      = 16;
    localparam int IW      = 7;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst;

    int totalChecks = 0;
    int passChecks  = 0;

    div_arbiter_if #(.N(N), .DW(DW), .IW(IW)) bus ();

    div_arbiter #(.N(N), .DW(DW), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
        .MHz10 (clk),
        .rst   (rst),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] defOperand(input int v);
        return DW'(32'h0A00 + v * 17);
    endfunction

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Bounded wait for the ISSUE cycle of the next grant.
    task automatic waitForStart(input string name);
        int c;
        c = 0;
        while (bus.div_start !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        totalChecks++;
        if (bus.div_start !== 1'b1)
            $display("[TB] FAIL %s_start_wait: div_start=%b required 1", name, bus.div_start);
        else passChecks++;
    endtask

    // Reset behaviour and quiet idle afterwards.
    task automatic test_reset();
        bus.en         = 1'b1;
        bus.req        = '0;
        bus.div_done   = 1'b0;
        bus.div_result = '0;
        for (int v = 0; v < N; v++) bus.operand[v*DW +: DW] = defOperand(v);
        doReset();
        totalChecks++;
        if (bus.timeout_err !== 1'b0)
            $display("[TB] FAIL reset_timeout_err: got %b required 0", bus.timeout_err);
        else passChecks++;
        for (int c = 0; c < 10; c++) begin
            step();
            totalChecks++;
            if (bus.busy !== 1'b0 || bus.div_start !== 1'b0 || bus.result_valid !== 1'b0
                || bus.ack !== '0)
                $display("[TB] FAIL reset_idle_strobes: busy=%b start=%b valid=%b ack=%h required 0",
                         bus.busy, bus.div_start, bus.result_valid, bus.ack);
            else passChecks++;
            totalChecks++;
            if (bus.result !== '0 || bus.result_id !== '0)
                $display("[TB] FAIL reset_result: result=%h id=%0d required 0/0",
                         bus.result, bus.result_id);
            else passChecks++;
        end
    endtask

    // Voice 3 alone, divider answering 5 cycles after start.
    task automatic test_single();
        bus.operand[3*DW +: DW] = 16'h1234;
        bus.req = 13'd1 << 3;
        step();
        totalChecks++;
        if (bus.div_start !== 1'b1 || bus.div_operand !== 16'h1234 || bus.busy !== 1'b1)
            $display("[TB] FAIL single_issue: start=%b operand=%h busy=%b required 1/1234/1",
                     bus.div_start, bus.div_operand, bus.busy);
        else passChecks++;
        for (int c = 2; c <= 6; c++) begin
            step();
            if (c == 2) bus.operand[3*DW +: DW] = 16'hFFFF;
            totalChecks++;
            if (bus.div_start !== 1'b0 || bus.result_valid !== 1'b0 || bus.div_operand !== 16'h1234)
                $display("[TB] FAIL single_wait: start=%b valid=%b operand=%h required 0/0/1234",
                         bus.div_start, bus.result_valid, bus.div_operand);
            else passChecks++;
        end
        bus.div_done   = 1'b1;
        bus.div_result = 16'h0042;
        step();
        bus.div_done = 1'b0;
        bus.req      = '0;
        totalChecks++;
        if (bus.result_valid !== 1'b1 || bus.result !== 16'h0042 || bus.result_id !== 7'd3)
            $display("[TB] FAIL single_result: valid=%b result=%h id=%0d required 1/0042/3",
                     bus.result_valid, bus.result, bus.result_id);
        else passChecks++;
        totalChecks++;
        if (bus.ack !== 13'h0008)
            $display("[TB] FAIL single_ack: got %h required 0008", bus.ack);
        else passChecks++;
        step();
        totalChecks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.ack !== '0 || bus.result !== 16'h0042)
            $display("[TB] FAIL single_return_idle: busy=%b valid=%b ack=%h result=%h required 0/0/0/0042",
                     bus.busy, bus.result_valid, bus.ack, bus.result);
        else passChecks++;
        bus.operand[3*DW +: DW] = defOperand(3);
    endtask

    // All voices requesting continuously with a one-cycle divider.
    task automatic test_round_robin();
        logic [N-1:0] expAck;
        int g;
        doReset();
        bus.req = '1;
        for (int k = 0; k <= N; k++) begin
            g = k % N;
            waitForStart("rr");
            totalChecks++;
            if (bus.div_operand !== defOperand(g) || bus.ack !== '0)
                $display("[TB] FAIL rr_grant_%0d: operand=%h ack=%h required %h/0",
                         k, bus.div_operand, bus.ack, defOperand(g));
            else passChecks++;
            step();
            bus.div_done   = 1'b1;
            bus.div_result = DW'(32'h0100 + g);
            step();
            bus.div_done = 1'b0;
            expAck       = '0;
            expAck[g]    = 1'b1;
            totalChecks++;
            if (bus.ack !== expAck || bus.result_valid !== 1'b1 || bus.result_id !== IW'(g)
                || bus.result !== DW'(32'h0100 + g))
                $display("[TB] FAIL rr_done_%0d: ack=%h id=%0d result=%h valid=%b required %h/%0d/%h/1",
                         k, bus.ack, bus.result_id, bus.result, bus.result_valid, expAck, g,
                         DW'(32'h0100 + g));
            else passChecks++;
            step();
        end
        bus.req = '0;
        step();
        step();
    endtask

    // Enable low while the divider pulses done: the pulse is lost.
    task automatic test_enable_freeze();
        bus.req = 13'd1 << 5;
        waitForStart("freeze");
        totalChecks++;
        if (bus.div_operand !== defOperand(5))
            $display("[TB] FAIL freeze_issue_operand: got %h required %h", bus.div_operand, defOperand(5));
        else passChecks++;
        step();
        bus.req                 = '0;
        bus.operand[5*DW +: DW] = 16'hBEEF;
        bus.en                  = 1'b0;
        bus.div_done            = 1'b1;
        bus.div_result          = 16'h1111;
        for (int c = 0; c < 4; c++) begin
            step();
            bus.div_done = 1'b0;
            totalChecks++;
            if (bus.busy !== 1'b1 || bus.div_start !== 1'b0 || bus.result_valid !== 1'b0
                || bus.ack !== '0 || bus.div_operand !== defOperand(5))
                $display("[TB] FAIL freeze_hold: busy=%b start=%b valid=%b ack=%h operand=%h required 1/0/0/0/%h",
                         bus.busy, bus.div_start, bus.result_valid, bus.ack, bus.div_operand,
                         defOperand(5));
            else passChecks++;
        end
        bus.en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            totalChecks++;
            if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0 || bus.ack !== '0)
                $display("[TB] FAIL freeze_still_wait: busy=%b valid=%b ack=%h required 1/0/0",
                         bus.busy, bus.result_valid, bus.ack);
            else passChecks++;
        end
        bus.div_done   = 1'b1;
        bus.div_result = 16'h0555;
        step();
        bus.div_done = 1'b0;
        totalChecks++;
        if (bus.result_valid !== 1'b1 || bus.result !== 16'h0555 || bus.result_id !== 7'd5
            || bus.ack !== 13'h0020)
            $display("[TB] FAIL freeze_result: valid=%b result=%h id=%0d ack=%h required 1/0555/5/0020",
                     bus.result_valid, bus.result, bus.result_id, bus.ack);
        else passChecks++;
        step();
        bus.div_done   = 1'b1;
        bus.div_result = 16'h2BAD;
        step();
        bus.div_done = 1'b0;
        step();
        totalChecks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== 16'h0555)
            $display("[TB] FAIL stray_done_idle: busy=%b valid=%b result=%h required 0/0/0555",
                     bus.busy, bus.result_valid, bus.result);
        else passChecks++;
        bus.operand[5*DW +: DW] = defOperand(5);
    endtask

    // Reset in WAIT aborts voice 9 and clears the pointer.
    task automatic test_reset_abort();
        bus.req = 13'd1 << 9;
        waitForStart("abort");
        totalChecks++;
        if (bus.div_operand !== defOperand(9))
            $display("[TB] FAIL abort_issue_operand: got %h required %h", bus.div_operand, defOperand(9));
        else passChecks++;
        step();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = '0;
        totalChecks++;
        if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.result_valid !== 1'b0
            || bus.result !== '0 || bus.result_id !== '0)
            $display("[TB] FAIL abort_state: busy=%b ack=%h valid=%b result=%h id=%0d required all 0",
                     bus.busy, bus.ack, bus.result_valid, bus.result, bus.result_id);
        else passChecks++;
        bus.div_done   = 1'b1;
        bus.div_result = 16'h0999;
        step();
        bus.div_done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            totalChecks++;
            if (bus.result_valid !== 1'b0 || bus.ack !== '0 || bus.busy !== 1'b0)
                $display("[TB] FAIL abort_stray_done: valid=%b ack=%h busy=%b required 0/0/0",
                         bus.result_valid, bus.ack, bus.busy);
            else passChecks++;
            step();
        end
        // With ptr back at 0, voice 2 beats voice 10.
        bus.req = (13'd1 << 2) | (13'd1 << 10);
        step();
        totalChecks++;
        if (bus.div_start !== 1'b1 || bus.div_operand !== defOperand(2))
            $display("[TB] FAIL abort_ptr_cleared: start=%b operand=%h required 1/%h",
                     bus.div_start, bus.div_operand, defOperand(2));
        else passChecks++;
        step();
        bus.div_done   = 1'b1;
        bus.div_result = 16'h2222;
        step();
        bus.div_done = 1'b0;
        bus.req      = '0;
        totalChecks++;
        if (bus.ack !== 13'h0004 || bus.result_id !== 7'd2 || bus.result !== 16'h2222)
            $display("[TB] FAIL abort_next_grant: ack=%h id=%0d result=%h required 0004/2/2222",
                     bus.ack, bus.result_id, bus.result);
        else passChecks++;
        step();
    endtask

`ifdef DIV_TIMEOUT_EN
    // Divider never answers: abort lands exactly TIMEOUT cycles after WAIT entry.
    task automatic test_timeout();
        bus.req = 13'd1 << 7;
        waitForStart("timeout");
        step();
        for (int c = 1; c < TIMEOUT; c++) begin
            step();
            totalChecks++;
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1)
                $display("[TB] FAIL timeout_early_%0d: valid=%b busy=%b required 0/1",
                         c, bus.result_valid, bus.busy);
            else passChecks++;
        end
        step();
        totalChecks++;
        if (bus.result_valid !== 1'b1 || bus.result !== '0 || bus.result_id !== 7'd7
            || bus.ack !== 13'h0080 || bus.timeout_err !== 1'b1)
            $display("[TB] FAIL timeout_abort: valid=%b result=%h id=%0d ack=%h err=%b required 1/0000/7/0080/1",
                     bus.result_valid, bus.result, bus.result_id, bus.ack, bus.timeout_err);
        else passChecks++;
        bus.req = '0;
        step();
        step();
        totalChecks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0)
            $display("[TB] FAIL timeout_sticky: err=%b busy=%b required 1/0", bus.timeout_err, bus.busy);
        else passChecks++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        totalChecks++;
        if (bus.timeout_err !== 1'b0)
            $display("[TB] FAIL timeout_err_cleared: got %b required 0", bus.timeout_err);
        else passChecks++;
    endtask
`else
    // Without the timeout feature a silent divider leaves the arbiter waiting.
    task automatic test_timeout();
        bus.req = 13'd1 << 7;
        waitForStart("no_timeout");
        step();
        for (int c = 0; c < TIMEOUT + 36; c++) begin
            step();
            totalChecks++;
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1 || bus.timeout_err !== 1'b0)
                $display("[TB] FAIL no_timeout_wait_%0d: valid=%b busy=%b err=%b required 0/1/0",
                         c, bus.result_valid, bus.busy, bus.timeout_err);
            else passChecks++;
        end
        bus.div_done   = 1'b1;
        bus.div_result = 16'h7777;
        step();
        bus.div_done = 1'b0;
        bus.req      = '0;
        totalChecks++;
        if (bus.result_valid !== 1'b1 || bus.result !== 16'h7777 || bus.ack !== 13'h0080)
            $display("[TB] FAIL no_timeout_result: valid=%b result=%h ack=%h required 1/7777/0080",
                     bus.result_valid, bus.result, bus.ack);
        else passChecks++;
        step();
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.req        = '0;
        bus.operand    = '0;
        bus.div_done   = 1'b0;
        bus.div_result = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_enable_freeze();
        test_reset_abort();
        test_timeout();
        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
